// File: rtl/top_level_pkg.sv
// Shared definitions for the error-diffusion dither engine: FSM state encoding,
// diffusion weights and the seven-segment decoder used when HEX_DISPLAY_EN is defined.
package states;

  typedef enum logic [2:0] {
    S0_IDLE = 3'd0,
    S1_LOAD = 3'd1,
    S2_CC1  = 3'd2,
    S2_CC2  = 3'd3,
    S2_CC3  = 3'd4,
    S2_CC4  = 3'd5,
    S4_CC1  = 3'd6,
    S5_DONE = 3'd7
  } state_t;

  // Neighbour slots in the order they are read and written back.
  localparam int NB_E  = 0;
  localparam int NB_SW = 1;
  localparam int NB_S  = 2;
  localparam int NB_SE = 3;

  localparam logic [2:0] W_E  = 3'd7;
  localparam logic [2:0] W_SW = 3'd3;
  localparam logic [2:0] W_S  = 3'd5;
  localparam logic [2:0] W_SE = 3'd1;

  // Active-low segments, bit order gfedcba.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dither_sram.sv
// Single-port synchronous image RAM with registered read; contents survive reset.
module dither_sram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic [AW-1:0]    addr,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/top_level.sv
// Image loader, Floyd-Steinberg style 1-bit ditherer and readout engine.
// Optional macro HEX_DISPLAY_EN drives HEX0-HEX5 with state or pixel index.
module top_level
  import states::*;
#(
  parameter int CLOCK_SPEED      = 50000000,
  parameter int PIXEL_COUNTER    = CLOCK_SPEED / 50000000,
  parameter int IMAGEX           = 16,
  parameter int IMAGEY           = 16,
  parameter int IMAGE_SIZE       = IMAGEX * IMAGEY,
  parameter int IMAGEXlog2       = $clog2(IMAGEX),
  parameter int IMAGEYlog2       = $clog2(IMAGEY),
  parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE),
  parameter int RGB_SIZE         = 8,
  parameter int ADJ_PIXELS       = 4
) (
  input  logic                MAX10_CLK1_50,
  input  logic                Reset,
  input  logic [1:0]          KEY,
  input  logic [9:0]          SW,
  input  logic                SPI_CLK,
  input  logic                SPI_MOSI,
  input  logic                SPI_CS,
  input  logic                MCU_TX_RDY,
  input  logic [RGB_SIZE-1:0] external_SPI_data,
  output logic                MCU_RX_RDY,
  output logic                data_valid,
  output logic [RGB_SIZE-1:0] sram_out_test,
  output logic                SPI_MISO,
  output state_t              state,
  output state_t              next_state,
  output logic [9:0]          LED,
  output logic [6:0]          HEX0,
  output logic [6:0]          HEX1,
  output logic [6:0]          HEX2,
  output logic [6:0]          HEX3,
  output logic [6:0]          HEX4,
  output logic [6:0]          HEX5
);

  localparam int AW = IMAGE_ADDR_WIDTH;
  localparam logic [AW-1:0]         ADDR_LAST = AW'(IMAGE_SIZE - 1);
  localparam logic [AW:0]           IDX_END   = (AW+1)'(IMAGE_SIZE);
  localparam logic [IMAGEXlog2-1:0] COL_LAST  = IMAGEXlog2'(IMAGEX - 1);
  localparam logic [IMAGEYlog2-1:0] ROW_LAST  = IMAGEYlog2'(IMAGEY - 1);

  logic [AW:0]           pix_idx;
  logic [AW-1:0]         pix_addr;
  logic [AW-1:0]         load_addr;
  logic [AW-1:0]         rd_addr;
  logic [2:0]            sub_cnt;
  logic [1:0]            sub_sel;
  logic [IMAGEXlog2-1:0] col;
  logic [IMAGEYlog2-1:0] row;

  logic [RGB_SIZE-1:0] old_pix;
  logic [RGB_SIZE-1:0] new_pix;
  logic [RGB_SIZE:0]   err;
  logic                err_neg;
  logic [RGB_SIZE:0]   err_mag;
  logic [RGB_SIZE:0]   q;

  logic [RGB_SIZE-1:0] nb_pix  [ADJ_PIXELS];
  logic [RGB_SIZE-1:0] nb_new  [ADJ_PIXELS];
  logic [AW-1:0]       nb_addr [ADJ_PIXELS];
  logic                nb_en   [ADJ_PIXELS];
  logic [2:0]          nb_w    [ADJ_PIXELS];
  logic [RGB_SIZE:0]   nb_adj  [ADJ_PIXELS];
  logic [RGB_SIZE:0]   nb_sum  [ADJ_PIXELS];

  logic [AW-1:0]       sram_addr;
  logic                sram_we;
  logic [RGB_SIZE-1:0] sram_wdata;
  logic [RGB_SIZE-1:0] sram_rdata;

  dither_sram #(
    .DEPTH (IMAGE_SIZE),
    .WIDTH (RGB_SIZE),
    .AW    (AW)
  ) u_sram (
    .clk   (MAX10_CLK1_50),
    .addr  (sram_addr),
    .we    (sram_we),
    .wdata (sram_wdata),
    .rdata (sram_rdata)
  );

  assign pix_addr = pix_idx[AW-1:0];
  assign col      = pix_idx[IMAGEXlog2-1:0];
  assign row      = pix_idx[IMAGEXlog2 +: IMAGEYlog2];
  // sub_cnt 1..4 in write-back selects neighbour 0..3.
  assign sub_sel  = 2'(sub_cnt - 3'd1);

  assign new_pix = old_pix[RGB_SIZE-1] ? '1 : '0;
  assign err     = {1'b0, old_pix} - {1'b0, new_pix};
  assign err_neg = err[RGB_SIZE];
  assign err_mag = err_neg ? (~err + 1'b1) : err;
  assign q       = err_mag >> 4;

  always_comb begin
    nb_addr[NB_E]  = pix_addr + AW'(1);
    nb_addr[NB_SW] = pix_addr + AW'(IMAGEX - 1);
    nb_addr[NB_S]  = pix_addr + AW'(IMAGEX);
    nb_addr[NB_SE] = pix_addr + AW'(IMAGEX + 1);
    nb_en[NB_E]    = (col != COL_LAST);
    nb_en[NB_SW]   = (row != ROW_LAST) && (col != '0);
    nb_en[NB_S]    = (row != ROW_LAST);
    nb_en[NB_SE]   = (col != COL_LAST) && (row != ROW_LAST);
    nb_w[NB_E]     = W_E;
    nb_w[NB_SW]    = W_SW;
    nb_w[NB_S]     = W_S;
    nb_w[NB_SE]    = W_SE;
    for (int k = 0; k < ADJ_PIXELS; k++) begin
      nb_adj[k] = q * (RGB_SIZE+1)'(nb_w[k]);
      nb_sum[k] = {1'b0, nb_pix[k]} + nb_adj[k];
      // Saturate instead of wrapping in either direction.
      if (err_neg) begin
        nb_new[k] = (nb_adj[k] > {1'b0, nb_pix[k]}) ? '0
                                                    : nb_pix[k] - nb_adj[k][RGB_SIZE-1:0];
      end else begin
        nb_new[k] = nb_sum[k][RGB_SIZE] ? '1 : nb_sum[k][RGB_SIZE-1:0];
      end
    end
  end

  always_comb begin
    sram_addr  = '0;
    sram_we    = 1'b0;
    sram_wdata = '0;
    case (state)
      S1_LOAD: begin
        sram_addr  = load_addr;
        sram_we    = 1'b1;
        sram_wdata = external_SPI_data;
      end
      S2_CC1: sram_addr = pix_addr;
      S2_CC2: sram_addr = nb_addr[sub_cnt[1:0]];
      S2_CC4: begin
        if (sub_cnt == 3'd0) begin
          sram_addr  = pix_addr;
          sram_we    = 1'b1;
          sram_wdata = new_pix;
        end else begin
          sram_addr  = nb_addr[sub_sel];
          sram_we    = nb_en[sub_sel];
          sram_wdata = nb_new[sub_sel];
        end
      end
      S4_CC1: sram_addr = rd_addr;
      default: ;
    endcase
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (Reset) begin
      state <= S0_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Read phase takes 4 cycles (one per neighbour), write-back 5 (pixel + 4).
  always_comb begin
    next_state = state;
    case (state)
      S0_IDLE: if (MCU_TX_RDY) next_state = S1_LOAD;
      S1_LOAD: if (load_addr == ADDR_LAST) next_state = S2_CC1;
      S2_CC1:  next_state = (pix_idx == IDX_END) ? S4_CC1 : S2_CC2;
      S2_CC2:  if (sub_cnt == 3'd3) next_state = S2_CC3;
      S2_CC3:  next_state = S2_CC4;
      S2_CC4:  if (sub_cnt == 3'd4) next_state = S2_CC1;
      S4_CC1:  if (rd_addr == ADDR_LAST) next_state = S5_DONE;
      S5_DONE: if (MCU_TX_RDY) next_state = S0_IDLE;
      default: next_state = S0_IDLE;
    endcase
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (Reset) begin
      pix_idx    <= '0;
      load_addr  <= '0;
      rd_addr    <= '0;
      sub_cnt    <= '0;
      old_pix    <= '0;
      data_valid <= 1'b0;
      MCU_RX_RDY <= 1'b0;
      for (int k = 0; k < ADJ_PIXELS; k++) begin
        nb_pix[k] <= '0;
      end
    end else begin
      data_valid <= (state == S4_CC1);
      MCU_RX_RDY <= (state == S4_CC1);
      case (state)
        S0_IDLE: load_addr <= '0;
        S1_LOAD: begin
          load_addr <= load_addr + AW'(1);
          pix_idx   <= '0;
        end
        S2_CC1: begin
          sub_cnt <= '0;
          rd_addr <= '0;
        end
        S2_CC2: begin
          // rdata holds the read issued in the previous cycle.
          if (sub_cnt == 3'd0) begin
            old_pix <= sram_rdata;
          end else begin
            nb_pix[sub_sel] <= sram_rdata;
          end
          sub_cnt <= (sub_cnt == 3'd3) ? 3'd0 : sub_cnt + 3'd1;
        end
        S2_CC3: begin
          nb_pix[NB_SE] <= sram_rdata;
          sub_cnt       <= '0;
        end
        S2_CC4: begin
          if (sub_cnt == 3'd4) begin
            sub_cnt <= '0;
            pix_idx <= pix_idx + (AW+1)'(1);
          end else begin
            sub_cnt <= sub_cnt + 3'd1;
          end
        end
        S4_CC1: rd_addr <= rd_addr + AW'(1);
        default: ;
      endcase
    end
  end

  assign sram_out_test = data_valid ? sram_rdata : '0;
  assign SPI_MISO      = MCU_RX_RDY & sram_out_test[RGB_SIZE-1];
  assign LED           = 10'b1 << 3'(state);

`ifdef HEX_DISPLAY_EN
  logic [31:0] refresh_cnt;
  logic [23:0] disp_val;
  logic        disp_on;

  always_ff @(posedge MAX10_CLK1_50) begin
    if (Reset) begin
      refresh_cnt <= '0;
      disp_val    <= '0;
      disp_on     <= 1'b0;
    end else if (refresh_cnt >= 32'(PIXEL_COUNTER - 1)) begin
      refresh_cnt <= '0;
      disp_on     <= 1'b1;
      disp_val    <= SW[0] ? 24'(pix_idx) : 24'(state);
    end else begin
      refresh_cnt <= refresh_cnt + 32'd1;
    end
  end

  assign HEX0 = disp_on ? seg7(disp_val[3:0])   : 7'h7F;
  assign HEX1 = disp_on ? seg7(disp_val[7:4])   : 7'h7F;
  assign HEX2 = disp_on ? seg7(disp_val[11:8])  : 7'h7F;
  assign HEX3 = disp_on ? seg7(disp_val[15:12]) : 7'h7F;
  assign HEX4 = disp_on ? seg7(disp_val[19:16]) : 7'h7F;
  assign HEX5 = disp_on ? seg7(disp_val[23:20]) : 7'h7F;
`else
  assign HEX0 = 7'h7F;
  assign HEX1 = 7'h7F;
  assign HEX2 = 7'h7F;
  assign HEX3 = 7'h7F;
  assign HEX4 = 7'h7F;
  assign HEX5 = 7'h7F;
`endif

  // Reserved pins and keys are sampled here only so they stay connected.
  logic unused_inputs;
  assign unused_inputs = ^{KEY, SW, SPI_CLK, SPI_MOSI, SPI_CS,
                           PIXEL_COUNTER[0], CLOCK_SPEED[0]};

endmodule

// File: tb/tb_top_level.sv
// Directed bench for top_level: image load, dither and readout against hand-computed images.
module tb_top_level;
  import states::*;

  localparam int N = 256;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] key;
  logic [9:0] sw;
  logic       spi_clk, spi_mosi, spi_cs;
  logic       mcu_tx_rdy;
  logic [7:0] ext_data;
  logic       mcu_rx_rdy, data_valid, spi_miso;
  logic [7:0] sram_out_test;
  state_t     state, next_state;
  logic [9:0] led;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] img[N];

  always #10 clk = ~clk;

  top_level dut (
    .MAX10_CLK1_50     (clk),
    .Reset             (reset),
    .KEY               (key),
    .SW                (sw),
    .SPI_CLK           (spi_clk),
    .SPI_MOSI          (spi_mosi),
    .SPI_CS            (spi_cs),
    .MCU_TX_RDY        (mcu_tx_rdy),
    .external_SPI_data (ext_data),
    .MCU_RX_RDY        (mcu_rx_rdy),
    .data_valid        (data_valid),
    .sram_out_test     (sram_out_test),
    .SPI_MISO          (spi_miso),
    .state             (state),
    .next_state        (next_state),
    .LED               (led),
    .HEX0              (hex0),
    .HEX1              (hex1),
    .HEX2              (hex2),
    .HEX3              (hex3),
    .HEX4              (hex4),
    .HEX5              (hex5)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_uniform(input logic [7:0] v, input logic [7:0] e);
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      img[i] = v;
      exp_q.push_back(e);
    end
  endtask

  task automatic load_image();
    mcu_tx_rdy = 1'b1;
    #1 check("next_state_load", next_state, S1_LOAD);
    tick();
    mcu_tx_rdy = 1'b0;
    check("state_load", state, S1_LOAD);
    for (int i = 0; i < N; i++) begin
      ext_data = img[i];
      tick();
    end
    check("state_after_load", state, S2_CC1);
  endtask

  task automatic readout(input string tag);
    int cyc;
    logic [7:0] e;
    cyc = 0;
    while (data_valid !== 1'b1 && cyc < 20000) begin
      tick();
      cyc++;
    end
    check({tag, " dv_start"}, data_valid, 1);
    for (int i = 0; i < N; i++) begin
      e = exp_q.pop_front();
      check($sformatf("%s dv[%0d]", tag, i), data_valid, 1);
      check($sformatf("%s rx[%0d]", tag, i), mcu_rx_rdy, 1);
      check($sformatf("%s pix[%0d]", tag, i), sram_out_test, e);
      check($sformatf("%s miso[%0d]", tag, i), spi_miso, e[7]);
      tick();
    end
    check({tag, " dv_end"}, data_valid, 0);
    check({tag, " rx_end"}, mcu_rx_rdy, 0);
    check({tag, " state_done"}, state, S5_DONE);
    mcu_tx_rdy = 1'b1;
    tick();
    mcu_tx_rdy = 1'b0;
    check({tag, " state_idle"}, state, S0_IDLE);
  endtask

  initial begin
    reset      = 1'b1;
    key        = 2'b00;
    sw         = 10'd0;
    spi_clk    = 1'b0;
    spi_mosi   = 1'b0;
    spi_cs     = 1'b1;
    mcu_tx_rdy = 1'b0;
    ext_data   = 8'h00;
    tick();
    tick();

    check("rst_state", state, S0_IDLE);
    check("rst_next_state", next_state, S0_IDLE);
    check("rst_data_valid", data_valid, 0);
    check("rst_rx_rdy", mcu_rx_rdy, 0);
    check("rst_sram_out", sram_out_test, 8'h00);
    check("rst_miso", spi_miso, 0);
    check("rst_led", led, 10'b00_0000_0001);
    check("rst_hex", {hex5, hex4, hex3, hex2, hex1, hex0}, {6{7'h7F}});
    reset = 1'b0;
    tick();
    check("idle_hold", state, S0_IDLE);

    set_uniform(8'hFF, 8'hFF);
    load_image();
    readout("all_ff");

    set_uniform(8'h00, 8'h00);
    load_image();
    readout("all_00");

    // (0,0)=0x70 pushes (0,1) to 161 -> 0xFF; its negative error clamps neighbours at 0.
    set_uniform(8'h00, 8'h00);
    img[0] = 8'h70;
    img[1] = 8'h70;
    exp_q[1] = 8'hFF;
    load_image();
    readout("two_px");

    set_uniform(8'hF0, 8'hFF);
    load_image();
    readout("all_f0");

    // 250+49 and 250+35 would wrap below 128 without saturation.
    set_uniform(8'hFA, 8'hFF);
    img[0] = 8'h7F;
    exp_q[0] = 8'h00;
    load_image();
    readout("sat_hi");

    // Right-edge pixel must not leak east into the start of the next row.
    set_uniform(8'h00, 8'h00);
    img[15] = 8'h70;
    img[16] = 8'h70;
    load_image();
    readout("right_edge");

    set_uniform(8'h70, 8'h00);
    load_image();
    for (int i = 0; i < 100; i++) tick();
    check("mid_dither_in_s2", (state >= S2_CC1) && (state <= S2_CC4), 1);
    reset = 1'b1;
    tick();
    check("mid_rst_state", state, S0_IDLE);
    check("mid_rst_dv", data_valid, 0);
    check("mid_rst_sram_out", sram_out_test, 8'h00);
    reset = 1'b0;
    tick();
    check("mid_rst_idle", state, S0_IDLE);
    set_uniform(8'hFF, 8'hFF);
    load_image();
    readout("after_reset");

    set_uniform(8'hF0, 8'hFF);
    load_image();
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 37; i++) tick();
      mcu_tx_rdy = 1'b1;
      tick();
      mcu_tx_rdy = 1'b0;
      check($sformatf("tx_ignored_%0d", p), (state >= S2_CC1) && (state <= S2_CC4), 1);
    end
    readout("tx_in_s2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
